seq_restoring_divider: RTL



---
 rtl/divider_pkg.sv | 12 +
 rtl/seq_restoring_divider_if.sv | 25 ++
 rtl/restoring_div_step.sv | 18 +
 rtl/seq_restoring_divider.sv | 84 ++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// divider_pkg: shared FSM state type and divide-by-zero quotient constant
// for the sequential restoring divider.
package divider_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    // All-ones pattern of width w (1..64); callers truncate to their width.
    function automatic logic [63:0] dbz_quotient(input int w);
        return ~64'd0 >> (64 - w);
    endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// seq_restoring_divider_if: operand and result valid/ready channels of the divider.
interface seq_restoring_divider_if #(
    parameter int N = 8,
    parameter int M = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] dividend;
    logic [M-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] q;
    logic [M-1:0] rem;
    logic         dbz;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, q, rem, dbz
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, q, rem, dbz
    );
endinterface

// File: rtl/restoring_div_step.sv
// restoring_div_step: one combinational restoring-division step (shift in a
// dividend bit, trial-subtract the divisor, keep or restore).
module restoring_div_step #(
    parameter int M = 4
) (
    input  logic [M:0]   p,
    input  logic         bit_in,
    input  logic [M-1:0] divisor,
    output logic [M:0]   p_next,
    output logic         q_bit
);
    logic [M+1:0] d;

    // The sign bit of the M+2 bit difference decides whether the subtraction fits.
    assign d      = {p, bit_in} - {2'b00, divisor};
    assign q_bit  = ~d[M+1];
    assign p_next = q_bit ? d[M:0] : {p[M-1:0], bit_in};
endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: iterative unsigned restoring divider, one quotient bit
// per clock, with valid/ready handshakes and divide-by-zero reporting.
module seq_restoring_divider
    import divider_pkg::*;
#(
    parameter int N = 8,
    parameter int M = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    seq_restoring_divider_if.slave bus
);
    localparam int CW = $clog2(N + 1);
    localparam logic [N-1:0] QDBZ = N'(dbz_quotient(N));

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [M:0]    p_q, p_d;
    logic [M-1:0]  div_q, div_d;
    logic [N-1:0]  sh_q, sh_d;
    logic          dbz_q, dbz_d;
    logic [M:0]    p_step;
    logic          q_bit;

    // sh_q shifts dividend bits out of the MSB while quotient bits enter the LSB.
    restoring_div_step #(.M(M)) u_step (
        .p      (p_q),
        .bit_in (sh_q[N-1]),
        .divisor(div_q),
        .p_next (p_step),
        .q_bit  (q_bit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        div_d   = div_q;
        sh_d    = sh_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                div_d   = bus.divisor;
                dbz_d   = bus.divisor == '0;
                state_d = dbz_d ? DONE : CALC;
                sh_d    = dbz_d ? QDBZ : bus.dividend;
                p_d     = dbz_d ? {1'b0, bus.dividend[M-1:0]} : '0;
                cnt_d   = CW'(N);
            end
            CALC: begin
                p_d     = p_step;
                sh_d    = {sh_q[N-2:0], q_bit};
                cnt_d   = cnt_q - CW'(1);
                state_d = cnt_q == CW'(1) ? DONE : CALC;
            end
            DONE:    state_d = bus.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            div_q   <= '0;
            sh_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            div_q   <= div_d;
            sh_q    <= sh_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.q         = sh_q;
    assign bus.rem       = p_q[M-1:0];
    assign bus.dbz       = dbz_q;
endmodule
